// File: rtl/instruction_aligner_if.sv
// rtl/instruction_aligner_if.sv - fetch-word in / instruction out handshake bundle for the aligner
interface instruction_aligner_if #(
    parameter int PC_WIDTH = 32
);
    logic [31:0]         in_word;
    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic [PC_WIDTH-1:0] flush_pc;
    logic [31:0]         out_instruction;
    logic                out_compressed;
    logic [PC_WIDTH-1:0] out_pc;
    logic                out_valid;
    logic                out_ready;

    // Fetch/redirect side plus instruction consumer, as seen by whoever drives the aligner
    modport master (
        output in_word, in_valid, flush, flush_pc, out_ready,
        input  in_ready, out_instruction, out_compressed, out_pc, out_valid
    );

    // The aligner itself
    modport slave (
        input  in_word, in_valid, flush, flush_pc, out_ready,
        output in_ready, out_instruction, out_compressed, out_pc, out_valid
    );
endinterface

// File: rtl/instruction_aligner.sv
// rtl/instruction_aligner.sv - halfword-queue realigner feeding the RVC decompressor
module instruction_aligner #(
    parameter int          PC_WIDTH = 32,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          BUF_HW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_aligner_if.slave bus
);
    localparam int CW = $clog2(BUF_HW + 1);

    logic [15:0]         hw_q [BUF_HW];
    logic [15:0]         hw_d [BUF_HW];
    logic [CW-1:0]       count_q, count_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                drop_lo_q, drop_lo_d;

    logic                head_c;
    logic                out_valid_w;
    logic                in_ready_w;
    logic [15:0]         push_hw0;
    logic [15:0]         push_hw1;
    int                  cnt;
    int                  pop_n;
    int                  push_n;
    int                  keep;

    // Handshake outputs and next buffer state; outputs only look at registered state and flush
    always_comb begin
        head_c      = (hw_q[0][1:0] != 2'b11);
        cnt         = int'(count_q);
        out_valid_w = !bus.flush && (cnt >= 1) && (head_c || cnt >= 2);
        in_ready_w  = !bus.flush && (cnt <= BUF_HW - 2);

        pop_n  = (out_valid_w && bus.out_ready) ? (head_c ? 1 : 2) : 0;
        push_n = (bus.in_valid && in_ready_w) ? (drop_lo_q ? 1 : 2) : 0;

        // After a redirect to an odd halfword, the lower half of the first word is skipped
        push_hw0 = drop_lo_q ? bus.in_word[31:16] : bus.in_word[15:0];
        push_hw1 = bus.in_word[31:16];

        // Survivors shift down by the popped amount, new halfwords land right after them
        keep = cnt - pop_n;
        for (int i = 0; i < BUF_HW; i++) begin
            hw_d[i] = hw_q[i];
            if (i < keep) begin
                hw_d[i] = hw_q[i + pop_n];
            end else if (i == keep && push_n >= 1) begin
                hw_d[i] = push_hw0;
            end else if (i == keep + 1 && push_n == 2) begin
                hw_d[i] = push_hw1;
            end
        end

        count_d   = CW'(cnt + push_n - pop_n);
        pc_d      = pc_q + PC_WIDTH'(pop_n * 2);
        drop_lo_d = drop_lo_q && (push_n == 0);

        bus.in_ready        = in_ready_w;
        bus.out_valid       = out_valid_w;
        bus.out_compressed  = head_c;
        bus.out_instruction = head_c ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
        bus.out_pc          = pc_q;
    end

    // State update: reset, then redirect, then normal push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            pc_q      <= PC_WIDTH'(RESET_PC);
            drop_lo_q <= 1'b0;
        end else if (bus.flush) begin
            count_q   <= '0;
            pc_q      <= {bus.flush_pc[PC_WIDTH-1:1], 1'b0};
            drop_lo_q <= bus.flush_pc[1];
        end else begin
            count_q   <= count_d;
            pc_q      <= pc_d;
            drop_lo_q <= drop_lo_d;
            hw_q      <= hw_d;
        end
    end
endmodule
